// File: rtl/vga_timing_gen.sv
// Parametrised display timing generator: a clock-enable divider paces the pixel counters,
// and every output is registered from the next-state counter values so all outputs stay aligned.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CLK_DIV   = 4,
   parameter int CNT_W     = 10
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic             pix_en,
   output logic             line_start,
   output logic             frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);

   // One extra bit so window ends equal to 2**CNT_W still compare correctly.
   localparam logic [CNT_W:0] H_VIS    = (CNT_W+1)'(H_VISIBLE);
   localparam logic [CNT_W:0] HS_START = (CNT_W+1)'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W:0] HS_END   = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CNT_W:0] V_VIS    = (CNT_W+1)'(V_VISIBLE);
   localparam logic [CNT_W:0] VS_START = (CNT_W+1)'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W:0] VS_END   = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

   if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
      $error("vga_timing_gen: sync widths must be at least 1");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
      $error("vga_timing_gen: CNT_W too narrow for the configured totals");
   end

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_next;
   logic [CNT_W-1:0] x_next;
   logic [CNT_W-1:0] y_next;
   logic             running;
   logic             hs_active;
   logic             vs_active;
   logic             video_next;
   logic             pix_next;
   logic             line_next;
   logic             frame_next;

   // The first clk after reset release shows pixel (0,0) without advancing anything,
   // so that pixel gets its full CLK_DIV clks.
   always_comb begin
      div_next = div_cnt;
      x_next   = x;
      y_next   = y;
      if (running) begin
         if (div_cnt == DIV_LAST) begin
            div_next = '0;
            if (x == X_LAST) begin
               x_next = '0;
               y_next = (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
               x_next = x + 1'b1;
            end
         end else begin
            div_next = div_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      hs_active  = ({1'b0, x_next} >= HS_START) && ({1'b0, x_next} < HS_END);
      vs_active  = ({1'b0, y_next} >= VS_START) && ({1'b0, y_next} < VS_END);
      video_next = ({1'b0, x_next} < H_VIS) && ({1'b0, y_next} < V_VIS);
      pix_next   = (div_next == DIV_LAST);
      line_next  = (div_next == '0) && (x_next == '0);
      frame_next = line_next && (y_next == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         running     <= 1'b0;
         div_cnt     <= '0;
         x           <= '0;
         y           <= '0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         video_on    <= 1'b0;
         pix_en      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         running     <= 1'b1;
         div_cnt     <= div_next;
         x           <= x_next;
         y           <= y_next;
         hsync       <= hs_active ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= vs_active ? VSYNC_POL : ~VSYNC_POL;
         video_on    <= video_next;
         pix_en      <= pix_next;
         line_start  <= line_next;
         frame_start <= frame_next;
      end
   end

endmodule
